// File: rtl/tinyalu_pkg.sv
// Shared ALU opcode encoding for the instruction sequencer and the ALU it drives.
// op_load and op_store are consumed by the sequencer and never reach the ALU.
package tinyalu_pkg;

    typedef enum logic [3:0] {
        op_nop   = 4'h0,
        op_add   = 4'h1,
        op_and   = 4'h2,
        op_xor   = 4'h3,
        op_mul   = 4'h4,
        op_load  = 4'h8,
        op_store = 4'h9
    } alu_opcode_t;

endpackage

// File: rtl/instr_seq_unit.sv
// Single-issue instruction sequencer: decodes one instruction per handshake and runs a load,
// store or ALU op to completion, with a per-operation timeout and a sticky error flag.
module instr_seq_unit
    import tinyalu_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned RSEL_W  = 1,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [4+ADDR_W+2*RSEL_W-1:0]    instr,
    input  logic                            instr_valid,
    output logic                            instr_ready,
    input  logic                            mem_done,
    input  logic [DATA_W-1:0]               data,
    input  logic                            alu_done,
    input  logic [2*DATA_W-1:0]             alu_result,
    output logic                            start,
    output logic [DATA_W-1:0]               A,
    output logic [DATA_W-1:0]               B,
    output alu_opcode_t                     op,
    output logic [ADDR_W-1:0]               addr,
    output logic [2*DATA_W-1:0]             result,
    output logic                            load,
    output logic                            store,
    output logic                            done,
    output logic                            err
);

    localparam int unsigned INSTR_W = 4 + ADDR_W + 2 * RSEL_W;
    localparam int unsigned Depth   = 2 ** RSEL_W;
    localparam int unsigned CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TLimit  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {StIdle, StLoad, StStore, StAlu} state_e;

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      rf_q [Depth];
    logic [DATA_W-1:0]      rf_d [Depth];
    logic [2*DATA_W-1:0]    result_q, result_d;
    logic [DATA_W-1:0]      a_q, a_d, b_q, b_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    alu_opcode_t            op_q, op_d;
    logic [RSEL_W-1:0]      rs_a_q, rs_a_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   start_q, start_d;
    logic                   load_q, load_d;
    logic                   store_q, store_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [3:0]             f_opcode;
    logic [ADDR_W-1:0]      f_addr;
    logic [RSEL_W-1:0]      f_rs_a, f_rs_b;
    logic                   timeout_hit;

    assign f_opcode = instr[INSTR_W-1 -: 4];
    assign f_addr   = instr[2*RSEL_W +: ADDR_W];
    assign f_rs_a   = instr[RSEL_W +: RSEL_W];
    assign f_rs_b   = instr[0 +: RSEL_W];

    // Expires on the last waiting cycle; a done sampled on that same edge takes priority.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TLimit));

    always_comb begin
        state_d  = state_q;
        rf_d     = rf_q;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
        addr_d   = addr_q;
        op_d     = op_q;
        rs_a_d   = rs_a_q;
        cnt_d    = cnt_q;
        start_d  = start_q;
        load_d   = load_q;
        store_d  = store_q;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    rs_a_d = f_rs_a;
                    cnt_d  = '0;
                    if (f_opcode == op_load) begin
                        addr_d  = f_addr;
                        load_d  = 1'b1;
                        state_d = StLoad;
                    end else if (f_opcode == op_store) begin
                        addr_d  = f_addr;
                        store_d = 1'b1;
                        state_d = StStore;
                    end else begin
                        op_d    = alu_opcode_t'(f_opcode);
                        a_d     = rf_q[f_rs_a];
                        b_d     = rf_q[f_rs_b];
                        start_d = 1'b1;
                        state_d = StAlu;
                    end
                end
            end
            StLoad: begin
                if (mem_done) begin
                    rf_d[rs_a_q] = data;
                    load_d       = 1'b0;
                    done_d       = 1'b1;
                    state_d      = StIdle;
                end else if (timeout_hit) begin
                    load_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStore: begin
                if (mem_done) begin
                    store_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    store_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StAlu: begin
                if (alu_done) begin
                    result_d = alu_result;
                    start_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else if (timeout_hit) begin
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            for (int i = 0; i < Depth; i++) rf_q[i] <= '0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            addr_q   <= '0;
            op_q     <= op_nop;
            rs_a_q   <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rf_q     <= rf_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            rs_a_q   <= rs_a_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            load_q   <= load_d;
            store_q  <= store_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign instr_ready = (state_q == StIdle);
    assign start       = start_q;
    assign A           = a_q;
    assign B           = b_q;
    assign op          = op_q;
    assign addr        = addr_q;
    assign result      = result_q;
    assign load        = load_q;
    assign store       = store_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: doc/instr_seq_unit.md
# instr_seq_unit

Parametrised, registered successor to the single-issue instruction unit: accepts one encoded instruction per valid/ready handshake, decodes it, and sequences either a memory load, a memory store, or an ALU operation through a state machine, holding each request until the matching done. Generalises the operand store to a register file of 2^RSEL_W entries, adds per-operation timeout with a sticky error flag, and sits between the instruction source and the ALU593 / memory-interface units.

## Interface
- DATA_W, 8, operand width; ALU result width is 2*DATA_W
- ADDR_W, 14, memory address width
- RSEL_W, 1, register-select width; register file depth 2^RSEL_W
- TIMEOUT, 1024, max cycles waiting for mem_done/alu_done; 0 disables timeout
- Derived: INSTR_W = 4+ADDR_W+2*RSEL_W; fields {opcode[3:0], addr, rs_a, rs_b} MSB to LSB
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- instr  in  INSTR_W  encoded instruction
- instr_valid  in  1  instr is valid
- instr_ready  out  1  unit idle, will accept instr this cycle
- mem_done  in  1  memory interface finished current load/store
- data  in  DATA_W  load data from memory interface, valid with mem_done
- alu_done  in  1  ALU finished current op
- alu_result  in  2*DATA_W  ALU result, valid with alu_done
- start  out  1  ALU start, held until alu_done
- A, B  out  DATA_W  ALU operands
- op  out  alu_opcode_t  ALU opcode (tinyalu_pkg)
- addr  out  ADDR_W  memory address
- result  out  2*DATA_W  last ALU result, store data to memory interface
- load, store  out  1  memory requests, held until mem_done
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, LOAD, STORE, ALU, each non-IDLE returns to IDLE.
- IDLE: instr_ready=1; on instr_valid, register fields; opcode==op_load -> LOAD, op_store -> STORE, any other -> ALU.
- LOAD: load=1, addr=decoded addr; on mem_done write data into reg[rs_a], pulse done, -> IDLE.
- STORE: store=1, addr=decoded addr, result presents last_result; on mem_done pulse done, -> IDLE.
- ALU: start=1, op=opcode, A=reg[rs_a], B=reg[rs_b] (values at accept, frozen); on alu_done capture alu_result into result, start=0, pulse done, -> IDLE.
- rs_a==rs_b legal: A and B equal.
- Timeout: counter cleared on entry to LOAD/STORE/ALU, increments each cycle waiting; at count TIMEOUT-1 with no done: drop request, err=1, no done pulse, -> IDLE.
- err set only by timeout, cleared only by reset.
- mem_done/alu_done outside their matching state are ignored (no state, register, or result change).
- instr_valid while busy ignored; source must hold it until accepted.

## Timing
- Reset (async assert, sync to clk on release): state IDLE, register file 0, result 0, A=B=0, addr=0, op=0, start=load=store=done=err=0, instr_ready=1.
- Accept on edge N (instr_valid&&instr_ready): request outputs high from cycle N+1; instr_ready low from N+1.
- Done sampled high on edge M: request low, done=1, instr_ready=1 in cycle M+1; done low at M+2 unless a new op completes.
- Minimum issue interval 2 cycles (done in first request cycle); done and next accept may coincide.
- Done and timeout on same edge: done wins, err unchanged.
- Reset mid-operation: request dropped immediately, no done pulse, register file cleared.
- addr, op hold last value in IDLE; A, B hold until next ALU accept.

## Test plan
- Load reg0=0x5A (addr 0x0123, mem_done 3 cycles later) -> load high 3 cycles, addr=0x0123, done pulse, reg0=0x5A.
- Load reg0=0x12, reg1=0x34, ALU op_add -> start held, A=0x12, B=0x34; alu_done with 0x0046 -> result=0x0046, done pulse, start low.
- Store after multiply 0xFF*0xFF -> store high, result=0xFE01, done on mem_done, instr_ready next cycle.
- TIMEOUT=8, load with mem_done never asserted -> load drops after 8 cycles, err=1, no done; later instructions still execute, err stays 1.
- Spurious alu_done during LOAD and mem_done in IDLE -> no state, register, or result change.
- reset_n low mid-ALU wait -> start, done, err, result 0 immediately; instr_ready=1 after release.
